dmem_initiator: RTL

- Request-side master for the data memory: accepts single read/write requests from the pipeline over a valid/ready handshake.
- Drives the memory's addr/enable/dataIn/readwrite port with one-hot chip selection.
- Waits the fixed memory read latency, captures dataOut and returns a response over a second valid/ready handshake.
- Sits between the load/store unit and the banked data memory; one transaction in flight at a time.

---
 rtl/dmem_initiator.sv | 113 +++++++++++
 1 files changed

// File: rtl/dmem_initiator.sv
// Data-memory request master: one read/write at a time, one-hot chip select, fixed read latency.
// Optional macro DMEM_INIT_ERR_EN adds rsp_err and rejects out-of-range addresses without touching memory.
module dmem_initiator #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int NUM_CHIPS  = 4,
   parameter int CHIP_WORDS = 16,
   parameter int READ_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DATA_W-1:0]    req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_write,
   output logic [DATA_W-1:0]    rsp_rdata,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic                 mem_enable,
   output logic [NUM_CHIPS-1:0] mem_chip_sel,
   output logic [DATA_W-1:0]    mem_dataIn,
   output logic                 mem_readwrite,
   input  logic [DATA_W-1:0]    mem_dataOut,
   output logic                 busy
`ifdef DMEM_INIT_ERR_EN
   ,
   output logic                 rsp_err
`endif
);

   localparam int CW_B = $clog2(CHIP_WORDS);
   localparam int NC_B = $clog2(NUM_CHIPS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0] state;
   logic [2:0] lat_cnt;

`ifdef DMEM_INIT_ERR_EN
   logic out_of_range;
   assign out_of_range = (req_addr >= ADDR_W'(NUM_CHIPS * CHIP_WORDS));
`endif

   assign req_ready  = (state == S_IDLE);
   assign rsp_valid  = (state == S_RESP);
   assign busy       = (state != S_IDLE);
   assign mem_enable = (state == S_ISSUE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         lat_cnt       <= '0;
         rsp_write     <= 1'b0;
         rsp_rdata     <= '0;
         mem_addr      <= '0;
         mem_chip_sel  <= '0;
         mem_dataIn    <= '0;
         mem_readwrite <= 1'b0;
`ifdef DMEM_INIT_ERR_EN
         rsp_err       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  // Memory-side outputs are latched here so they stay stable through WAIT and RESP.
                  mem_readwrite <= req_write;
                  mem_addr      <= req_addr & ADDR_W'(CHIP_WORDS - 1);
                  mem_chip_sel  <= NUM_CHIPS'(1) << req_addr[CW_B +: NC_B];
                  mem_dataIn    <= req_wdata;
                  rsp_write     <= req_write;
                  rsp_rdata     <= '0;
                  state         <= S_ISSUE;
`ifdef DMEM_INIT_ERR_EN
                  rsp_err       <= out_of_range;
                  if (out_of_range) begin
                     state <= S_RESP;
                  end
`endif
               end
            end
            S_ISSUE: begin
               if (mem_readwrite) begin
                  state <= S_RESP;
               end else begin
                  lat_cnt <= 3'(READ_LAT);
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  rsp_rdata <= mem_dataOut;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
